// File: rtl/seq_multiplier.sv
// seq_multiplier: parametrised sequential shift-add multiplier.
// Operands are captured on an accepted start. Signed operands are reduced to
// magnitudes, WIDTH shift-add iterations build the unsigned magnitude product,
// and a final FIX cycle restores the sign and publishes the result.
// Latency from the accepting edge to prod/eop is WIDTH+1 clocks.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod,
    output logic               eop,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Magnitude of an operand. The most negative value maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits, so no extra bit is carried.
    function automatic logic [WIDTH-1:0] magnitude(
        input logic [WIDTH-1:0] x,
        input logic             sgn
    );
        logic [WIDTH-1:0] m;
        if (sgn && x[WIDTH-1]) begin
            m = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            m = x;
        end
        return m;
    endfunction

    // Re-apply the product sign to the unsigned magnitude product.
    function automatic logic [PW-1:0] apply_sign(
        input logic [PW-1:0] v,
        input logic          neg
    );
        logic [PW-1:0] r;
        if (neg) begin
            r = ~v + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // State and datapath registers
    logic [1:0]       state_r;
    logic             mode_r;
    logic             neg_r;
    logic [WIDTH-1:0] mag_a_r;
    logic [WIDTH-1:0] mag_b_r;
    logic [PW-1:0]    acc_r;
    logic [CW-1:0]    cnt_r;
    logic [PW-1:0]    prod_r;
    logic             eop_r;
    logic             busy_r;

    // Next-state values
    logic [1:0]       state_s;
    logic             mode_s;
    logic             neg_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [PW-1:0]    acc_s;
    logic [CW-1:0]    cnt_s;
    logic [PW-1:0]    prod_s;
    logic             eop_s;
    logic             busy_s;
    logic [PW-1:0]    addend_s;

    // Partial product for the current iteration: multiplicand shifted by bit index.
    always_comb begin
        addend_s = {{WIDTH{1'b0}}, mag_b_r} << cnt_r;
    end

    // FSM next-state and datapath update; every register holds unless its state updates it.
    always_comb begin
        state_s = state_r;
        mode_s  = mode_r;
        neg_s   = neg_r;
        mag_a_s = mag_a_r;
        mag_b_s = mag_b_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        prod_s  = prod_r;
        eop_s   = 1'b0;
        busy_s  = busy_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = CALC;
                    mode_s  = signed_mode;
                    mag_a_s = magnitude(a, signed_mode);
                    mag_b_s = magnitude(b, signed_mode);
                    neg_s   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_s   = {PW{1'b0}};
                    cnt_s   = {CW{1'b0}};
                    busy_s  = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            CALC: begin
                if (mag_a_r[cnt_r]) begin
                    acc_s = acc_r + addend_s;
                end else begin
                    acc_s = acc_r;
                end
                if (cnt_r == CNT_LAST) begin
                    state_s = FIX;
                    cnt_s   = cnt_r;
                end else begin
                    state_s = CALC;
                    cnt_s   = cnt_r + CNT_ONE;
                end
                busy_s = 1'b1;
            end
            FIX: begin
                prod_s  = apply_sign(acc_r, neg_r);
                eop_s   = 1'b1;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                eop_s   = 1'b0;
            end
        endcase
    end

    // Register update; reset aborts any operation in flight and clears all state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            mode_r  <= 1'b0;
            neg_r   <= 1'b0;
            mag_a_r <= {WIDTH{1'b0}};
            mag_b_r <= {WIDTH{1'b0}};
            acc_r   <= {PW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            prod_r  <= {PW{1'b0}};
            eop_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            mode_r  <= mode_s;
            neg_r   <= neg_s;
            mag_a_r <= mag_a_s;
            mag_b_r <= mag_b_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            prod_r  <= prod_s;
            eop_r   <= eop_s;
            busy_r  <= busy_s;
        end
    end

    assign prod = prod_r;
    assign eop  = eop_r;
    assign busy = busy_r;

endmodule
